// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle for the data cache controller.
// The slave modport is the cache controller. The master modport is the MEM stage
// together with the backing memory.
interface dcache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    input  cpu_rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    output cpu_rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// The controller drives hit low to freeze the MEM/WB register while it waits on memory.
// It also keeps saturating read hit and read miss counters.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  dcache_if.slave          bus,
  output logic [CNT_W-1:0] rd_hit_cnt,
  output logic [CNT_W-1:0] rd_miss_cnt
);

  localparam int unsigned Lines = 2 ** INDEX_BITS;
  localparam int unsigned TagW  = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru, StWrDone} state_e;

  state_e                  state_q, state_d;
  logic [Lines-1:0]        valid_q;
  logic [TagW-1:0]         tag_q  [Lines];
  logic [DATA_W-1:0]       data_q [Lines];
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

  logic [INDEX_BITS-1:0]   index;
  logic [TagW-1:0]         tag;
  logic                    lookup_hit;
  logic                    line_we;
  logic                    line_fill;
  logic [DATA_W-1:0]       line_wdata;
  logic                    hit_inc;
  logic                    miss_inc;
  logic                    unused_addr;

  assign index       = bus.cpu_addr[INDEX_BITS+1:2];
  assign tag         = bus.cpu_addr[ADDR_W-1:INDEX_BITS+2];
  assign lookup_hit  = valid_q[index] && (tag_q[index] == tag);
  assign unused_addr = ^bus.cpu_addr[1:0];

  // Next-state, memory request registers and pipeline-facing outputs
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    bus.hit       = 1'b0;
    bus.cpu_rdata = '0;
    line_we       = 1'b0;
    line_fill     = 1'b0;
    line_wdata    = bus.mem_rdata;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.hit = 1'b1;
        if (bus.cpu_wr) begin
          // A store wins over a simultaneous load
          bus.hit     = 1'b0;
          state_d     = StWrThru;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = bus.cpu_wdata;
        end else if (bus.cpu_rd) begin
          if (lookup_hit) begin
            bus.cpu_rdata = data_q[index];
            hit_inc       = 1'b1;
          end else begin
            bus.hit    = 1'b0;
            miss_inc   = 1'b1;
            state_d    = StRdMiss;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      StRdMiss: begin
        if (mem_req_q && bus.mem_ready) begin
          line_we   = 1'b1;
          line_fill = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StWrThru: begin
        if (mem_req_q && bus.mem_ready) begin
          // Update only a line that is already present; misses do not allocate
          line_we    = lookup_hit;
          line_wdata = bus.cpu_wdata;
          mem_req_d  = 1'b0;
          state_d    = StWrDone;
        end
      end
      StWrDone: begin
        // One release cycle so the pipeline moves past the store without re-issuing it
        bus.hit = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    hit_cnt_d  = (hit_inc && (hit_cnt_q != '1)) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    miss_cnt_d = (miss_inc && (miss_cnt_q != '1)) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end

  // Control state, valid bits and counters with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (line_we && line_fill) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data storage; the write is suppressed during reset so an aborted refill leaves no trace
  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      data_q[index] <= line_wdata;
      if (line_fill) begin
        tag_q[index] <= tag;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign rd_hit_cnt    = hit_cnt_q;
  assign rd_miss_cnt   = miss_cnt_q;

endmodule
